// File: rtl/mpram_write_scheduler_if.sv
// Write-request bus between the write-back/commit sources and the scheduler.
// master: requester side (drives valid/we/addr/data); slave: scheduler side (drives ready).
interface mpram_write_scheduler_if #(
  parameter int REQ_NUM    = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int BYTES_NUM  = 1
);
  logic [REQ_NUM-1:0]                 req_valid_i;
  logic [REQ_NUM-1:0]                 req_ready_o;
  logic [REQ_NUM-1:0][BYTES_NUM-1:0]  req_we_i;
  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0] req_data_i;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i,
    output req_ready_o
  );
endinterface

// File: rtl/mpram_write_scheduler.sv
// Round-robin write scheduler for the LVT multi-port RAM: shares WPORTS_NUM
// write ports among REQ_NUM requesters, one grant per address per cycle,
// outputs registered (1-cycle latency), optional zero-fill sweep after reset.
// Ports: clk, rst (sync, active-high); req (slave request bus: valid/ready/
// we/addr/data); en_w_o/we_o/waddr_o/data_o (RAM write ports); init_done_o.
// Optional: `define MPRAM_SCHED_STARVE_GUARD_EN adds per-requester wait
// counters that force a starving requester to the front of the scan.
module mpram_write_scheduler #(
  parameter int REQ_NUM          = 8,
  parameter int WPORTS_NUM       = 2,
  parameter int DATA_DEPTH       = 128,
  parameter int DATA_WIDTH       = 64,
  parameter int BYTE_WRITE_WIDTH = 64,
  parameter int INIT_ON_RESET    = 1,
  localparam int ADDR_WIDTH      = $clog2(DATA_DEPTH),
  localparam int BYTES_NUM       = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  mpram_write_scheduler_if.slave                req,
  output logic [WPORTS_NUM-1:0]                 en_w_o,
  output logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_o,
  output logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] waddr_o,
  output logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_o,
  output logic                                  init_done_o
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] init_cnt_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] scan_start;
  logic             run;

  logic [REQ_NUM-1:0]                grant;
  logic [WPORTS_NUM-1:0]             sel_vld;
  logic [WPORTS_NUM-1:0][PTR_W-1:0]  sel_idx;

  assign run             = (state_q == S_RUN);
  assign init_done_o     = run;
  assign req.req_ready_o = grant & {REQ_NUM{run & ~rst}};

`ifdef MPRAM_SCHED_STARVE_GUARD_EN
  logic [REQ_NUM-1:0][3:0] wait_q;

  // A saturated waiter takes the scan head; lowest index wins.
  always_comb begin : starve_pick
    logic found;
    found      = 1'b0;
    scan_start = rr_ptr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && wait_q[i] == 4'hF) begin
        scan_start = PTR_W'(i);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (run) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (req.req_valid_i[i] && !grant[i])
          wait_q[i] <= (wait_q[i] == 4'hF) ? 4'hF : wait_q[i] + 4'd1;
        else
          wait_q[i] <= 4'd0;
      end
    end
  end
`else
  assign scan_start = rr_ptr_q;
`endif

  // Scan from scan_start; k-th grant lands on port k, and an address
  // already granted this cycle blocks later requesters with the same one.
  always_comb begin : arb
    int   idx;
    int   np;
    logic clash;
    grant    = '0;
    sel_vld  = '0;
    sel_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    idx      = 0;
    np       = 0;
    clash    = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(scan_start) + k;
      if (idx >= REQ_NUM)
        idx = idx - REQ_NUM;
      clash = 1'b0;
      for (int p = 0; p < WPORTS_NUM; p++) begin
        if (p < np && req.req_addr_i[sel_idx[p]] == req.req_addr_i[idx])
          clash = 1'b1;
      end
      if (req.req_valid_i[idx] && np < WPORTS_NUM && !clash) begin
        grant[idx]   = 1'b1;
        sel_vld[np]  = 1'b1;
        sel_idx[np]  = PTR_W'(idx);
        np           = np + 1;
        rr_ptr_d     = (idx == REQ_NUM - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      en_w_o     <= '0;
      we_o       <= '0;
      waddr_o    <= '0;
      data_o     <= '0;
    end else if (state_q == S_INIT) begin
      en_w_o <= '0;
      we_o   <= '0;
      // Counter runs one past the last address so RUN starts only after
      // the final zero write has been presented on port 0.
      if (init_cnt_q < CNT_W'(DATA_DEPTH)) begin
        en_w_o[0]  <= 1'b1;
        we_o[0]    <= '1;
        waddr_o[0] <= init_cnt_q[ADDR_WIDTH-1:0];
        data_o[0]  <= '0;
        init_cnt_q <= init_cnt_q + CNT_W'(1);
      end else begin
        state_q <= S_RUN;
      end
    end else begin
      for (int p = 0; p < WPORTS_NUM; p++) begin
        en_w_o[p] <= sel_vld[p];
        if (sel_vld[p]) begin
          we_o[p]    <= req.req_we_i[sel_idx[p]];
          waddr_o[p] <= req.req_addr_i[sel_idx[p]];
          data_o[p]  <= req.req_data_i[sel_idx[p]];
        end else begin
          we_o[p] <= '0;
        end
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mpram_write_scheduler.sv
// Directed bench for mpram_write_scheduler: init sweep, saturation,
// address conflict, wrap-around, mid-init reset, optional starve guard.
module tb_mpram_write_scheduler;

  localparam int RN = 8;
  localparam int WP = 2;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int BN = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WP-1:0]          en_w;
  logic [WP-1:0][BN-1:0]  we;
  logic [WP-1:0][AW-1:0]  waddr;
  logic [WP-1:0][DW-1:0]  wdata;
  logic                   idone;

  mpram_write_scheduler_if #(
    .REQ_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES_NUM(BN)
  ) rif ();

  mpram_write_scheduler #(
    .REQ_NUM(RN), .WPORTS_NUM(WP), .DATA_DEPTH(128),
    .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(64), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .req(rif),
    .en_w_o(en_w), .we_o(we), .waddr_o(waddr),
    .data_o(wdata), .init_done_o(idone)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic w);
    rif.req_addr_i[i] = a;
    rif.req_data_i[i] = d;
    rif.req_we_i[i]   = w;
  endtask

  int bad_w;
  int bad_r;
  int got;

  initial begin
    rst = 1'b1;
    rif.req_valid_i = '1;
    for (int i = 0; i < RN; i++)
      set_req(i, AW'(i + 1), 64'hA000 + DW'(i), 1'b1);

    step();
    check("rst_en_w", en_w, 0);
    check("rst_waddr", waddr, 0);
    check("rst_data0", wdata[0], 0);
    check("rst_idone", idone, 0);
    mid();
    check("rst_ready", rif.req_ready_o, 0);
    step();
    rst = 1'b0;

    bad_w = 0;
    bad_r = 0;
    mid();
    if (rif.req_ready_o !== '0) bad_r++;
    for (int c = 0; c < 128; c++) begin
      step();
      if (en_w !== 2'b01 || waddr[0] !== AW'(c) || wdata[0] !== '0 ||
          we[0] !== 1'b1 || idone !== 1'b0)
        bad_w++;
      mid();
      if (rif.req_ready_o !== '0) bad_r++;
    end
    rif.req_valid_i = '0;
    check("init_writes_bad", bad_w, 0);
    check("init_ready_bad", bad_r, 0);
    check("init_done_low_at_127", idone, 0);
    step();
    check("init_done_rise", idone, 1);
    check("init_port_idle", en_w, 0);

    // port saturation
    set_req(0, 7'd5, 64'h1111, 1'b1);
    set_req(1, 7'd6, 64'h2222, 1'b1);
    set_req(2, 7'd7, 64'h3333, 1'b1);
    rif.req_valid_i = 8'h07;
    mid();
    check("sat_ready", rif.req_ready_o, 8'h03);
    step();
    check("sat_en_w", en_w, 2'b11);
    check("sat_addr0", waddr[0], 5);
    check("sat_addr1", waddr[1], 6);
    check("sat_data0", wdata[0], 64'h1111);
    check("sat_data1", wdata[1], 64'h2222);
    check("sat_rr_ptr", dut.rr_ptr_q, 2);
    rif.req_valid_i = 8'h04;
    mid();
    check("sat_ready2", rif.req_ready_o, 8'h04);
    step();
    check("sat2_en_w", en_w, 2'b01);
    check("sat2_addr0", waddr[0], 7);
    rif.req_valid_i = 8'h00;

    // address conflict, rr_ptr is 3 here
    set_req(3, 7'h10, 64'h4444, 1'b1);
    set_req(4, 7'h10, 64'h5555, 1'b1);
    rif.req_valid_i = 8'h18;
    mid();
    check("cfl_ready", rif.req_ready_o, 8'h08);
    step();
    check("cfl_en_w", en_w, 2'b01);
    check("cfl_data0", wdata[0], 64'h4444);
    check("cfl_hold_addr1", waddr[1], 6);
    check("cfl_we1", we[1], 0);
    rif.req_valid_i = 8'h10;
    mid();
    check("cfl_ready2", rif.req_ready_o, 8'h10);
    step();
    check("cfl2_en_w", en_w, 2'b01);
    check("cfl2_data0", wdata[0], 64'h5555);
    check("cfl2_rr_ptr", dut.rr_ptr_q, 5);

    // move pointer to 7, then wrap
    set_req(6, 7'h20, 64'h6666, 1'b1);
    rif.req_valid_i = 8'h40;
    mid();
    check("wrap_pre_ready", rif.req_ready_o, 8'h40);
    step();
    set_req(7, 7'h30, 64'h7777, 1'b1);
    set_req(0, 7'h31, 64'h8888, 1'b0);
    rif.req_valid_i = 8'h81;
    mid();
    check("wrap_ready", rif.req_ready_o, 8'h81);
    step();
    check("wrap_en_w", en_w, 2'b11);
    check("wrap_addr0", waddr[0], 7'h30);
    check("wrap_addr1", waddr[1], 7'h31);
    check("wrap_we0", we[0], 1);
    check("wrap_we1_zero", we[1], 0);
    check("wrap_data1", wdata[1], 64'h8888);
    check("wrap_rr_ptr", dut.rr_ptr_q, 1);
    rif.req_valid_i = 8'h00;
    mid();
    check("idle_ready", rif.req_ready_o, 0);
    step();
    check("idle_en_w", en_w, 0);
    check("idle_rr_hold", dut.rr_ptr_q, 1);

`ifdef MPRAM_SCHED_STARVE_GUARD_EN
    for (int i = 0; i < 6; i++)
      set_req(i, 7'h40 + AW'(i), 64'hB000 + DW'(i), 1'b1);
    rif.req_valid_i = 8'h3F;
    got = 0;
    for (int c = 0; c < 16 && got == 0; c++) begin
      mid();
      if (rif.req_ready_o[5]) got = 1;
      step();
    end
    check("starve_grant5", got, 1);
    rif.req_valid_i = 8'h00;
    step();
`endif

    // reset in RUN, then again mid-sweep
    for (int i = 0; i < RN; i++)
      set_req(i, AW'(i + 1), 64'hC000 + DW'(i), 1'b1);
    rif.req_valid_i = '1;
    rst = 1'b1;
    mid();
    check("rst_run_ready", rif.req_ready_o, 0);
    step();
    check("rst_run_en_w", en_w, 0);
    check("rst_run_idone", idone, 0);
    rst = 1'b0;
    bad_w = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (en_w !== 2'b01 || waddr[0] !== AW'(c)) bad_w++;
    end
    check("sweep2_bad", bad_w, 0);
    check("sweep2_cnt40", dut.init_cnt_q, 40);
    rst = 1'b1;
    mid();
    check("rst_mid_ready", rif.req_ready_o, 0);
    step();
    check("rst_mid_en_w", en_w, 0);
    check("rst_mid_addr", waddr[0], 0);
    rst = 1'b0;
    step();
    check("restart_en_w", en_w, 2'b01);
    check("restart_addr", waddr[0], 0);
    mid();
    check("restart_ready", rif.req_ready_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
